// File: rtl/tl_pkg.sv
// Shared TileLink-lite definitions: channel widths, field positions, opcodes and FSM encoding.
// Masters, slaves and the memory responder all import this package.
package tl_pkg;

  localparam int A_W = 55;
  localparam int D_W = 47;

  localparam int A_OP_LSB   = 52;
  localparam int A_MASK_LSB = 48;
  localparam int A_SRC_LSB  = 42;
  localparam int A_DATA_LSB = 10;
  localparam int A_ADDR_LSB = 0;

  localparam int D_OP_LSB   = 44;
  localparam int D_DEN_BIT  = 43;
  localparam int D_SRC_LSB  = 37;
  localparam int D_DATA_LSB = 5;

  localparam logic [2:0] A_PUT_FULL    = 3'b000;
  localparam logic [2:0] A_PUT_PARTIAL = 3'b001;
  localparam logic [2:0] A_GET         = 3'b100;
  localparam logic [2:0] D_ACK         = 3'b000;
  localparam logic [2:0] D_ACK_DATA    = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // Field order mirrors the A-channel bit layout, so a plain cast unpacks it.
  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  mask;
    logic [5:0]  src;
    logic [31:0] data;
    logic [9:0]  addr;
  } a_req_t;

  function automatic a_req_t unpack_a(input logic [A_W-1:0] w);
    return a_req_t'(w);
  endfunction

  function automatic logic [D_W-1:0] pack_d(input logic [2:0] op, input logic den,
                                            input logic [5:0] src, input logic [31:0] data);
    return {op, den, src, data, 5'b0};
  endfunction

endpackage

// File: rtl/mem_array_bm.sv
// DEPTH x 32 word array: byte-masked synchronous write, combinational read, synchronous clear.
// Out-of-range addresses read as zero and never write.
module mem_array_bm #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic          in_range;
  logic [IW-1:0] idx;

  assign in_range = 32'(addr_i) < DEPTH;
  assign idx      = addr_i[IW-1:0];
  assign rdata_o  = in_range ? mem_q[idx] : '0;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/tl_mem_responder.sv
// Single-outstanding TileLink-lite memory slave: accept, wait ACCESS_LATENCY cycles,
// perform the access, then hold the response until the requester takes it.
module tl_mem_responder
  import tl_pkg::*;
#(
  parameter int A_CHANNEL_SIZE = 55,
  parameter int D_CHANNEL_SIZE = 47,
  parameter int MEM_DEPTH      = 1024,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [A_CHANNEL_SIZE-1:0] a_channel,
  input  logic                      a_valid,
  output logic                      a_ready,
  output logic [D_CHANNEL_SIZE-1:0] d_channel,
  output logic                      d_valid,
  input  logic                      d_ready
);
  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  a_req_t                    req_q, req_d;
  logic [D_CHANNEL_SIZE-1:0] d_q, d_d;
  logic                      rdy_q, rdy_d;

  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        in_range, is_put, is_get;

  mem_array_bm #(.DEPTH(MEM_DEPTH), .ADDR_W(10)) u_mem (
    .clk    (clk),
    .clr_i  (reset),
    .we_i   (mem_we),
    .addr_i (req_q.addr),
    .be_i   (req_q.mask),
    .wdata_i(req_q.data),
    .rdata_o(mem_rdata)
  );

  assign in_range = 32'(req_q.addr) < MEM_DEPTH;
  assign is_put   = (req_q.op == A_PUT_FULL) || (req_q.op == A_PUT_PARTIAL);
  assign is_get   = (req_q.op == A_GET);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    d_d     = d_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (a_valid && rdy_q) begin
          req_d   = unpack_a(A_W'(a_channel));
          cnt_d   = 4'(ACCESS_LATENCY);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        // The memory is touched only on the final ACCESS edge, so an abort leaves it intact.
        if (cnt_q == 4'd1) begin
          mem_we  = is_put && in_range;
          d_d     = D_CHANNEL_SIZE'(pack_d(is_get ? D_ACK_DATA : D_ACK,
                                           !(is_put || is_get) || !in_range,
                                           req_q.src,
                                           (is_get && in_range) ? mem_rdata : 32'd0));
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (d_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      d_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      d_q     <= d_d;
      rdy_q   <= rdy_d;
    end
  end

  assign a_ready   = rdy_q;
  assign d_valid   = (state_q == ST_RESPOND);
  assign d_channel = d_q;

endmodule

// File: tb/tb_tl_mem_responder.sv
// Directed bench for tl_mem_responder (MEM_DEPTH=512, ACCESS_LATENCY=2).
module tb_tl_mem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [54:0] a_channel;
  logic        a_valid;
  logic        a_ready;
  logic [46:0] d_channel;
  logic        d_valid;
  logic        d_ready;

  int errors = 0;
  int checks = 0;

  tl_mem_responder #(
    .A_CHANNEL_SIZE(55),
    .D_CHANNEL_SIZE(47),
    .MEM_DEPTH     (512),
    .ACCESS_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_channel(a_channel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .d_channel(d_channel),
    .d_valid  (d_valid),
    .d_ready  (d_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [46:0] exp_d(input logic [2:0] op, input logic den,
                                        input logic [5:0] src, input logic [31:0] data);
    return {op, den, src, data, 5'b00000};
  endfunction

  task automatic send(input logic [2:0] op, input logic [3:0] m, input logic [5:0] s,
                      input logic [31:0] d, input logic [9:0] a);
    a_channel = {op, m, s, d, a};
    a_valid   = 1'b1;
    step();
    a_valid   = 1'b0;
    a_channel = '0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!d_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic run_txn(input string tag, input logic [2:0] op, input logic [3:0] m,
                         input logic [5:0] s, input logic [31:0] d, input logic [9:0] a,
                         input logic [46:0] exp);
    int lat;
    send(op, m, s, d, a);
    chk({tag, "_busy"}, 64'(a_ready), 64'd0);
    wait_resp(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(LAT));
    chk({tag, "_d"}, 64'(d_channel), 64'(exp));
    step();
    chk({tag, "_dv_low"}, 64'(d_valid), 64'd0);
    chk({tag, "_ardy"}, 64'(a_ready), 64'd1);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    a_valid   = 1'b0;
    a_channel = '0;
    d_ready   = 1'b1;
    step();
    step();
    chk("rst_ardy", 64'(a_ready), 64'd0);
    chk("rst_dvld", 64'(d_valid), 64'd0);
    chk("rst_dch", 64'(d_channel), 64'd0);
    reset = 1'b0;
    chk("rst_ardy_pre_edge", 64'(a_ready), 64'd0);
    step();
    chk("rst_ardy_rise", 64'(a_ready), 64'd1);

    run_txn("putfull5", 3'b000, 4'hF, 6'd3, 32'd20, 10'd5, exp_d(3'b000, 1'b0, 6'd3, 32'd0));
    run_txn("get5_a", 3'b100, 4'h0, 6'd7, 32'd0, 10'd5, exp_d(3'b001, 1'b0, 6'd7, 32'd20));
    run_txn("putpart5", 3'b001, 4'b0010, 6'd9, 32'hAABBCCDD, 10'd5,
            exp_d(3'b000, 1'b0, 6'd9, 32'd0));
    run_txn("get5_b", 3'b100, 4'hF, 6'd1, 32'd0, 10'd5, exp_d(3'b001, 1'b0, 6'd1, 32'h0000CC14));

    // Back-pressure: response must hold while d_ready is low, busy-time requests ignored.
    d_ready = 1'b0;
    send(3'b100, 4'h0, 6'd2, 32'd0, 10'd5);
    wait_resp(lat);
    chk("stall_lat", 64'(lat), 64'(LAT));
    chk("stall_d0", 64'(d_channel), 64'(exp_d(3'b001, 1'b0, 6'd2, 32'h0000CC14)));
    for (int i = 0; i < 5; i++) begin
      a_valid   = (i % 2 == 0);
      a_channel = {3'b000, 4'hF, 6'd33, 32'hFFFFFFFF, 10'd5};
      step();
      chk("stall_dvld", 64'(d_valid), 64'd1);
      chk("stall_dch", 64'(d_channel), 64'(exp_d(3'b001, 1'b0, 6'd2, 32'h0000CC14)));
      chk("stall_ardy", 64'(a_ready), 64'd0);
    end
    a_valid   = 1'b0;
    a_channel = '0;
    d_ready   = 1'b1;
    step();
    chk("stall_hs_dvld", 64'(d_valid), 64'd0);
    chk("stall_hs_ardy", 64'(a_ready), 64'd1);
    step();
    chk("stall_single_resp", 64'(d_valid), 64'd0);

    run_txn("badop", 3'b111, 4'hF, 6'd4, 32'h12345678, 10'd5, exp_d(3'b000, 1'b1, 6'd4, 32'd0));
    run_txn("get600", 3'b100, 4'h0, 6'd5, 32'd0, 10'd600, exp_d(3'b001, 1'b1, 6'd5, 32'd0));
    run_txn("put600", 3'b000, 4'hF, 6'd8, 32'hDEADBEEF, 10'd600,
            exp_d(3'b000, 1'b1, 6'd8, 32'd0));
    run_txn("get5_c", 3'b100, 4'h0, 6'd6, 32'd0, 10'd5, exp_d(3'b001, 1'b0, 6'd6, 32'h0000CC14));
    run_txn("get88", 3'b100, 4'h0, 6'd10, 32'd0, 10'd88, exp_d(3'b001, 1'b0, 6'd10, 32'd0));

    // Reset in the middle of ACCESS aborts the write and clears memory.
    send(3'b000, 4'hF, 6'd11, 32'h12345678, 10'd9);
    reset = 1'b1;
    step();
    chk("abort_dvld", 64'(d_valid), 64'd0);
    chk("abort_ardy", 64'(a_ready), 64'd0);
    chk("abort_dch", 64'(d_channel), 64'd0);
    reset = 1'b0;
    step();
    chk("abort_dvld2", 64'(d_valid), 64'd0);
    chk("abort_ardy2", 64'(a_ready), 64'd1);
    step();
    chk("abort_no_resp", 64'(d_valid), 64'd0);
    run_txn("get9", 3'b100, 4'h0, 6'd12, 32'd0, 10'd9, exp_d(3'b001, 1'b0, 6'd12, 32'd0));
    run_txn("get5_clr", 3'b100, 4'h0, 6'd13, 32'd0, 10'd5, exp_d(3'b001, 1'b0, 6'd13, 32'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_mem_responder.md
TL_MEM_RESPONDER -- requirements
Module: tl_mem_responder

Interface
REQ-001 SHALL have parameter A_CHANNEL_SIZE, default 55, A-channel request word width.
REQ-002 SHALL have parameter D_CHANNEL_SIZE, default 47, D-channel response word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words; legal range 1..1024.
REQ-004 SHALL have parameter ACCESS_LATENCY, default 2, cycles spent in ACCESS; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock, all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port a_channel  input  A_CHANNEL_SIZE  request: [54:52] opcode, [51:48] byte mask, [47:42] source, [41:10] data, [9:0] word address.
REQ-008 SHALL have port a_valid  input  1  request present on a_channel.
REQ-009 SHALL have port a_ready  output  1  responder accepts a request this cycle.
REQ-010 SHALL have port d_channel  output  D_CHANNEL_SIZE  response: [46:44] opcode, [43] denied, [42:37] source, [36:5] data, [4:0] reserved, always zero.
REQ-011 SHALL have port d_valid  output  1  response present on d_channel.
REQ-012 SHALL have port d_ready  input  1  requester (response FIFO not full) accepts the response.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESPOND -> IDLE; a_ready=1 only in IDLE; d_valid=1 only in RESPOND.
REQ-014 SHALL accept a request on a posedge with a_valid && a_ready, capturing all A fields into holding registers and entering ACCESS with latency counter = ACCESS_LATENCY.
REQ-015 SHALL decrement the counter on each ACCESS posedge; on the posedge at which it reaches 0, perform the memory operation, register d_channel, and enter RESPOND.
REQ-016 Latency: request accepted at edge N gives d_valid=1 after edge N+ACCESS_LATENCY.
REQ-017 SHALL treat opcode 3'b000 (PutFull) and 3'b001 (PutPartial) as writes: byte i of the addressed word written iff mask[i]=1; response opcode 3'b000 (AccessAck), data 0.
REQ-018 SHALL treat opcode 3'b100 (Get) as a read: response opcode 3'b001 (AccessAckData), data = full 32-bit word; mask ignored.
REQ-019 For any other opcode: memory unchanged; response opcode 3'b000, denied=1, data 0.
REQ-020 For address >= MEM_DEPTH: memory unchanged; denied=1, data 0, opcode per REQ-017/018.
REQ-021 SHALL echo the captured source in every response.
REQ-022 SHALL hold d_channel and d_valid stable in RESPOND until d_ready=1; on edge with d_valid && d_ready, go to IDLE (a_ready=1, d_valid=0 after that edge).
REQ-023 SHALL ignore a_valid outside IDLE; a_channel changes while busy do not affect the transaction in flight.
REQ-024 d_ready=1 in the first RESPOND cycle SHALL complete the handshake at the next edge; minimum throughput is one transaction per ACCESS_LATENCY+2 cycles.
REQ-025 A write SHALL be visible to any Get accepted after its response handshake.

Reset
REQ-026 With reset=1 at a posedge: state IDLE, a_ready=0, d_valid=0, d_channel=0, counter=0, holding registers 0, all memory words 0.
REQ-027 a_ready SHALL rise after the first posedge with reset=0.
REQ-028 Reset during ACCESS or RESPOND SHALL abort the transaction; no response is issued and no partial write is committed.

Structure
REQ-029 Package tl_pkg SHALL hold channel widths, field bit positions, A/D opcode constants, and the FSM state encoding; master, slave and this block share it.
REQ-030 Sub-module mem_array_bm SHALL implement the MEM_DEPTH x 32 byte-masked synchronous-write, combinational-read array with synchronous clear.

Verification
REQ-031 Reset, then PutFull addr 5, mask 4'hF, data 20, source 3; d_ready=1 -> d_valid 2 cycles after accept, opcode 000, denied 0, source 3, data 0.
REQ-032 Then Get addr 5, source 7 -> opcode 001, data 32'd20, source 7.
REQ-033 PutPartial addr 5, mask 4'b0010, data 32'hAABBCCDD; then Get addr 5 -> data 32'h0000CC14.
REQ-034 d_ready held 0 for 5 cycles during RESPOND -> d_valid and d_channel stable; a_valid pulses ignored; one handshake when d_ready rises.
REQ-035 Opcode 3'b111, and (MEM_DEPTH=512) Get addr 600 -> denied=1, data 0; following Get of addr 5 unchanged.
REQ-036 Reset asserted in ACCESS of a PutFull to addr 9 -> no response; after reset, Get addr 9 returns 0.
